led_blink_scheduler: RTL and testbench

Command-driven controller for the 8-bit board LED bank. It accepts mode, period and mask commands over a valid/ready handshake. It derives a 1 ms time base from the system clock and sequences the LEDs through off, solid, blink or chase patterns. It sits between control logic (switch decoder or soft processor) and the `led` pins, replacing free-running blinker counters.

---
 rtl/led_sched_pkg.sv | 29 ++
 rtl/led_blink_scheduler_tick_gen.sv | 28 ++
 rtl/led_blink_scheduler.sv | 102 ++++++++++
 tb/tb_led_blink_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// rtl/led_sched_pkg.sv - shared types and pattern helpers for the LED blink scheduler
package led_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Isolates the least significant set bit; zero in gives zero out.
  function automatic logic [7:0] lowest_bit(input logic [7:0] mask);
    return mask & (~mask + 8'd1);
  endfunction

  // Next set bit of mask strictly above cur, wrapping to the lowest set bit.
  function automatic logic [7:0] next_chase(input logic [7:0] cur, input logic [7:0] mask);
    logic [7:0] above;
    above = mask & ~(cur | (cur - 8'd1));
    return (above != 8'd0) ? lowest_bit(above) : lowest_bit(mask);
  endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// rtl/led_blink_scheduler_tick_gen.sv - prescaler producing a one-cycle tick every DIV clocks
module blink_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// rtl/led_blink_scheduler.sv - command-driven LED pattern sequencer (off/solid/blink/chase)
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_mode,
  input  logic [15:0] cmd_period_ms,
  input  logic [7:0]  cmd_mask,
  output logic [7:0]  led,
  output logic        busy
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("led_blink_scheduler: CLK_HZ must be a multiple of TICK_HZ giving DIV >= 2");
  end

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_RUN  = ST_RUN;

  logic [1:0]  state;
  mode_t       mode_r;
  logic [15:0] period_r;
  logic [7:0]  mask_r;
  logic [15:0] phase;
  logic        tick;
  logic        accept;

  assign cmd_ready = (state != S_LOAD);
  assign accept    = cmd_valid && cmd_ready;

  blink_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (state == S_LOAD),
    .tick  (tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      mode_r   <= MODE_OFF;
      period_r <= '0;
      mask_r   <= '0;
      phase    <= '0;
      led      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          phase <= '0;
          case (mode_r)
            MODE_OFF:   led <= 8'h00;
            MODE_SOLID: led <= mask_r;
            MODE_BLINK: led <= mask_r;
            MODE_CHASE: led <= lowest_bit(mask_r);
            default:    led <= 8'h00;
          endcase
          if (mode_r == MODE_BLINK || mode_r == MODE_CHASE) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          // A new command takes priority over any step due on the same edge.
          if (accept) begin
            mode_r   <= mode_t'(cmd_mode);
            period_r <= (cmd_period_ms == 16'd0) ? 16'd1 : cmd_period_ms;
            mask_r   <= cmd_mask;
            state    <= S_LOAD;
            busy     <= 1'b0;
          end else if (state == S_RUN && tick) begin
            if (phase == period_r - 16'd1) begin
              phase <= '0;
              if (mode_r == MODE_BLINK) begin
                led <= led ^ mask_r;
              end else if (mode_r == MODE_CHASE) begin
                led <= next_chase(led, mask_r);
              end
            end else begin
              phase <= phase + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// tb/tb_led_blink_scheduler.sv - scoreboard bench for led_blink_scheduler with DIV=10
module tb_led_blink_scheduler;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_mode;
  logic [15:0] cmd_period_ms;
  logic [7:0]  cmd_mask;
  logic [7:0]  led;
  logic        busy;

  led_blink_scheduler #(
    .CLK_HZ  (1000),
    .TICK_HZ (100)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_mode      (cmd_mode),
    .cmd_period_ms (cmd_period_ms),
    .cmd_mask      (cmd_mask),
    .led           (led),
    .busy          (busy)
  );

  typedef struct {
    int         at;
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got ready/busy/led=%b/%b/%h, expected %b/%b/%h",
               name, cyc, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic void push(input int at, input logic r, input logic b,
                               input logic [7:0] l, input string name);
    exp_t e;
    e.at   = at;
    e.exp  = {r, b, l};
    e.name = name;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation scheduled for the cycle just completed.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        check(sb[i].name, {cmd_ready, busy, led}, sb[i].exp);
        sb.delete(i);
      end else if (sb[i].at < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", sb[i].name, sb[i].at, cyc);
        sb.delete(i);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Drives a command so that it is accepted on edge a.
  task automatic send(input int a, input logic [1:0] m, input logic [15:0] p, input logic [7:0] k);
    wait_until(a - 1);
    cmd_valid     = 1'b1;
    cmd_mode      = m;
    cmd_period_ms = p;
    cmd_mask      = k;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  int a;
  int e;

  initial begin
    reset         = 1'b1;
    cmd_valid     = 1'b0;
    cmd_mode      = 2'd0;
    cmd_period_ms = 16'd0;
    cmd_mask      = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_state", {cmd_ready, busy, led}, {1'b1, 1'b0, 8'h00});

    // SOLID hold
    a = cyc + 3; e = a + 1;
    push(a,       1'b0, 1'b0, 8'h00, "solid_load");
    push(e,       1'b1, 1'b0, 8'hA5, "solid_e");
    push(e + 100, 1'b1, 1'b0, 8'hA5, "solid_e100");
    push(e + 200, 1'b1, 1'b0, 8'hA5, "solid_e200");
    send(a, 2'd1, 16'd5, 8'hA5);
    wait_until(e + 202);

    // BLINK period 3
    a = cyc + 3; e = a + 1;
    push(a,      1'b0, 1'b0, 8'hA5, "blink_load");
    push(e,      1'b1, 1'b1, 8'hFF, "blink_e");
    push(e + 29, 1'b1, 1'b1, 8'hFF, "blink_e29");
    push(e + 30, 1'b1, 1'b1, 8'h00, "blink_e30");
    push(e + 59, 1'b1, 1'b1, 8'h00, "blink_e59");
    push(e + 60, 1'b1, 1'b1, 8'hFF, "blink_e60");
    send(a, 2'd2, 16'd3, 8'hFF);
    wait_until(e + 64);

    // CHASE wrap, issued while the blink is still running
    a = e + 66; e = a + 1;
    push(a,      1'b0, 1'b0, 8'hFF, "chase_load");
    push(e,      1'b1, 1'b1, 8'h02, "chase_e");
    push(e + 9,  1'b1, 1'b1, 8'h02, "chase_e9");
    push(e + 10, 1'b1, 1'b1, 8'h04, "chase_e10");
    push(e + 20, 1'b1, 1'b1, 8'h10, "chase_e20");
    push(e + 30, 1'b1, 1'b1, 8'h02, "chase_wrap");
    send(a, 2'd3, 16'd1, 8'h16);
    wait_until(e + 33);

    // Command/step collision
    a = cyc + 3; e = a + 1;
    push(e,      1'b1, 1'b1, 8'h3C, "coll_blink_e");
    push(e + 10, 1'b1, 1'b1, 8'h00, "coll_step1");
    push(e + 19, 1'b1, 1'b1, 8'h00, "coll_pre");
    push(e + 20, 1'b0, 1'b0, 8'h00, "coll_no_toggle");
    push(e + 21, 1'b1, 1'b0, 8'h00, "coll_off_e");
    push(e + 40, 1'b1, 1'b0, 8'h00, "coll_off_hold");
    send(a, 2'd2, 16'd1, 8'h3C);
    send(e + 20, 2'd0, 16'd1, 8'hFF);
    wait_until(e + 42);

    // Period 0 behaves as 1, then reset mid-run
    a = cyc + 3; e = a + 1;
    push(e,      1'b1, 1'b1, 8'h81, "p0_e");
    push(e + 10, 1'b1, 1'b1, 8'h00, "p0_e10");
    push(e + 20, 1'b1, 1'b1, 8'h81, "p0_e20");
    send(a, 2'd2, 16'd0, 8'h81);
    wait_until(e + 25);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {cmd_ready, busy, led}, {1'b1, 1'b0, 8'h00});
    cmd_valid     = 1'b1;
    cmd_mode      = 2'd1;
    cmd_period_ms = 16'd4;
    cmd_mask      = 8'h0F;
    repeat (3) @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    push(cyc + 1,  1'b1, 1'b0, 8'h00, "post_reset_idle1");
    push(cyc + 30, 1'b1, 1'b0, 8'h00, "post_reset_idle30");
    wait_until(cyc + 32);

    // CHASE with a single-bit mask holds the lit bit
    a = cyc + 3; e = a + 1;
    push(e,      1'b1, 1'b1, 8'h40, "chase1_e");
    push(e + 20, 1'b1, 1'b1, 8'h40, "chase1_e20");
    push(e + 40, 1'b1, 1'b1, 8'h40, "chase1_e40");
    send(a, 2'd3, 16'd2, 8'h40);

    for (int t = 0; t < 500 && sb.size() != 0; t++) @(negedge clock);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cyc %0d still pending at timeout", sb[0].name, sb[0].at);
      void'(sb.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
